// File: rtl/othello_turn_ctrl.sv
// Othello turn controller: repaints the board, accepts moves or passes,
// sequences board detect/write cycles and tracks the side to play.
module othello_turn_ctrl #(
  parameter int DETECT_CYCLES = 8,
  parameter int WRITE_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       move_valid,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  input  logic       pass_req,
  input  logic       plot_ready,
  input  logic [7:0] dir,
  input  logic [1:0] q,
  output logic       move_ready,
  output logic       detecten,
  output logic       writeen,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [1:0] side,
  output logic       move_ok,
  output logic       move_bad,
  output logic       plot_valid,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [1:0] plot_colour,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_DRAW, S_IDLE, S_DETECT, S_EVAL, S_WRITE, S_SWITCH
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] DET_LAST = CW'(DETECT_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WRITE_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_side;
  logic [1:0]      r_pass_cnt;
  logic            r_game_over;
  logic [2:0]      r_lx;
  logic [2:0]      r_ly;
  logic            w_plot_acc;
  logic            w_move_go;
  logic            w_pass_go;
  logic            w_cnt_done;
  logic [2:0]      w_x;
  logic [2:0]      w_y;

  assign w_plot_acc = (r_state == S_DRAW) && plot_ready;
  assign w_move_go  = (r_state == S_IDLE) && move_valid && !r_game_over;
  assign w_pass_go  = (r_state == S_IDLE) && pass_req && !move_valid && !r_game_over;
  assign w_cnt_done = ((r_state == S_DETECT) && (r_cnt == DET_LAST)) ||
                      ((r_state == S_WRITE)  && (r_cnt == WR_LAST));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_DRAW;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DRAW:   if (w_plot_acc && (r_idx == 6'd63)) w_next = S_IDLE;
      S_IDLE:   if (w_move_go) w_next = S_DETECT;
      S_DETECT: if (w_cnt_done) w_next = S_EVAL;
      S_EVAL:   w_next = (dir != 8'd0) ? S_WRITE : S_IDLE;
      S_WRITE:  if (w_cnt_done) w_next = S_SWITCH;
      S_SWITCH: w_next = S_DRAW;
      default:  w_next = S_DRAW;
    endcase
  end

  // idx wraps 63->0 on the final accept, so every sweep starts from cell 0
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_side      <= 2'd3;
      r_pass_cnt  <= '0;
      r_game_over <= 1'b0;
      r_lx        <= '0;
      r_ly        <= '0;
    end else begin
      if (w_plot_acc) r_idx <= r_idx + 6'd1;
      if ((r_state == S_DETECT) || (r_state == S_WRITE))
        r_cnt <= w_cnt_done ? '0 : r_cnt + CW'(1);
      if (w_move_go) begin
        r_lx <= move_x;
        r_ly <= move_y;
      end
      if (w_pass_go) begin
        r_side[0]  <= ~r_side[0];
        r_pass_cnt <= r_pass_cnt + 2'd1;
        if (r_pass_cnt == 2'd1) r_game_over <= 1'b1;
      end
      if (r_state == S_SWITCH) begin
        r_side[0]  <= ~r_side[0];
        r_pass_cnt <= '0;
      end
    end
  end

  // plot_valid is masked by resetn so nothing is offered while held in reset
  always_comb begin
    move_ready = (r_state == S_IDLE);
    detecten   = (r_state == S_DETECT);
    writeen    = (r_state == S_WRITE);
    plot_valid = (r_state == S_DRAW) && resetn;
    move_ok    = (r_state == S_SWITCH);
    move_bad   = (r_state == S_EVAL) && (dir == 8'd0);
    if (r_state == S_DRAW) begin
      w_x = r_idx[2:0];
      w_y = r_idx[5:3];
    end else begin
      w_x = r_lx;
      w_y = r_ly;
    end
  end

  assign x           = w_x;
  assign y           = w_y;
  assign side        = r_side;
  assign game_over   = r_game_over;
  assign plot_colour = q;
  assign plot_x      = (8'(w_x) * 8'd13) + 8'd9;
  assign plot_y      = (7'(w_y) * 7'd13) + 7'd9;

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Scoreboard bench for othello_turn_ctrl: directed moves, passes, stalls and resets.
module tb_othello_turn_ctrl;

  localparam int K_PLOT = 0, K_DET = 1, K_WR = 2, K_OK = 3, K_BAD = 4, K_GO = 5;

  typedef struct { int kind; int a; int b; int c; } ev_t;
  typedef struct {
    int id; int pv; int px; int py; int col; int mr;
    int de; int we; int sd; int go; int sx; int sy;
  } snap_t;

  ev_t   exp_q[$];
  snap_t snap_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    done = 1'b0;

  logic       clock = 1'b0;
  logic       resetn;
  logic       move_valid;
  logic [2:0] move_x, move_y;
  logic       pass_req, plot_ready;
  logic [7:0] dir;
  logic [1:0] q;
  logic       move_ready, detecten, writeen, move_ok, move_bad, plot_valid, game_over;
  logic [2:0] x, y;
  logic [1:0] side, plot_colour;
  logic [7:0] plot_x;
  logic [6:0] plot_y;

  othello_turn_ctrl dut (
    .clock(clock), .resetn(resetn), .move_valid(move_valid), .move_x(move_x),
    .move_y(move_y), .pass_req(pass_req), .plot_ready(plot_ready), .dir(dir), .q(q),
    .move_ready(move_ready), .detecten(detecten), .writeen(writeen), .x(x), .y(y),
    .side(side), .move_ok(move_ok), .move_bad(move_bad), .plot_valid(plot_valid),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // board contents seen by the controller: a fixed pattern of the address
  assign q = x[1:0] ^ y[1:0];

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 64; i++)
      push_ev(K_PLOT, 13 * (i % 8) + 9, 13 * (i / 8) + 9, ((i % 8) ^ (i / 8)) & 3);
  endtask

  task automatic push_snap(input int id, input int pv, input int px, input int py,
                           input int col, input int mr, input int de, input int we,
                           input int sd, input int go, input int sx, input int sy);
    snap_t s;
    s.id = id; s.pv = pv; s.px = px; s.py = py; s.col = col; s.mr = mr;
    s.de = de; s.we = we; s.sd = sd; s.go = go; s.sx = sx; s.sy = sy;
    snap_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!move_ready) begin
      tick();
      n++;
      if (n > 1000) begin
        $display("FAIL timeout_%s: move_ready=0 after %0d cycles, required 1", tag, n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic wait_ok(input string tag);
    int n = 0;
    while (!move_ok) begin
      tick();
      n++;
      if (n > 1000) begin
        $display("FAIL timeout_%s: move_ok=0 after %0d cycles, required 1", tag, n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic do_move(input logic [2:0] mx, input logic [2:0] my,
                         input logic [7:0] d, input logic with_pass);
    move_x = mx; move_y = my; dir = d;
    move_valid = 1'b1; pass_req = with_pass;
    tick();
    move_valid = 1'b0; pass_req = 1'b0;
  endtask

  // ---------------- checking side ----------------
  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic got_ev(input int k, input int a, input int b, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", k), 1, 0);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        n_errors++;
        $display("FAIL event: got kind%0d (%0d,%0d,%0d), required kind%0d (%0d,%0d,%0d)",
                 k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic cmp_snap(input snap_t s);
    if (s.pv  >= 0) chk($sformatf("snap%0d.plot_valid", s.id), int'(plot_valid), s.pv);
    if (s.px  >= 0) chk($sformatf("snap%0d.plot_x", s.id), int'(plot_x), s.px);
    if (s.py  >= 0) chk($sformatf("snap%0d.plot_y", s.id), int'(plot_y), s.py);
    if (s.col >= 0) chk($sformatf("snap%0d.plot_colour", s.id), int'(plot_colour), s.col);
    if (s.mr  >= 0) chk($sformatf("snap%0d.move_ready", s.id), int'(move_ready), s.mr);
    if (s.de  >= 0) chk($sformatf("snap%0d.detecten", s.id), int'(detecten), s.de);
    if (s.we  >= 0) chk($sformatf("snap%0d.writeen", s.id), int'(writeen), s.we);
    if (s.sd  >= 0) chk($sformatf("snap%0d.side", s.id), int'(side), s.sd);
    if (s.go  >= 0) chk($sformatf("snap%0d.game_over", s.id), int'(game_over), s.go);
    if (s.sx  >= 0) chk($sformatf("snap%0d.x", s.id), int'(x), s.sx);
    if (s.sy  >= 0) chk($sformatf("snap%0d.y", s.id), int'(y), s.sy);
  endtask

  initial begin : monitor
    int det_len = 0, det_x = 0, det_y = 0;
    int wr_len = 0, wr_gap = 0, wr_xy = 0, gap = 0;
    bit go_prev = 1'b0;
    snap_t s;
    forever begin
      @(negedge clock);
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        cmp_snap(s);
      end
      chk("no_overlap", int'(detecten && writeen), 0);
      if (plot_valid && plot_ready) got_ev(K_PLOT, int'(plot_x), int'(plot_y), int'(plot_colour));
      if (detecten) begin
        det_len++; det_x = int'(x); det_y = int'(y); gap = 0;
      end else if (det_len > 0) begin
        got_ev(K_DET, det_len, det_x, det_y);
        det_len = 0;
      end
      if (writeen) begin
        if (wr_len == 0) wr_gap = gap;
        wr_len++; wr_xy = int'(x) * 8 + int'(y);
      end else if (wr_len > 0) begin
        got_ev(K_WR, wr_len, wr_gap, wr_xy);
        wr_len = 0;
      end
      if (!detecten && !writeen) gap++;
      if (move_ok)  got_ev(K_OK, int'(side), 0, 0);
      if (move_bad) got_ev(K_BAD, int'(side), gap, 0);
      if (game_over && !go_prev) got_ev(K_GO, int'(side), 0, 0);
      go_prev = game_over;
      if (done) begin
        chk("queues_drained", exp_q.size() + snap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  // ---------------- stimulus side ----------------
  initial begin : stimulus
    resetn = 1'b0; move_valid = 1'b0; move_x = '0; move_y = '0;
    pass_req = 1'b0; plot_ready = 1'b1; dir = '0;
    repeat (2) @(posedge clock);
    #1;
    push_snap(1, 0, -1, -1, -1, 0, 0, 0, 3, 0, 0, 0);
    tick(); tick();

    // reset release: full sweep of 64 cells, first one visible immediately
    push_sweep();
    resetn = 1'b1;
    push_snap(2, 1, 9, 9, 0, 0, 0, 0, 3, 0, -1, -1);
    tick();
    wait_ready("sweep0");
    push_snap(3, 0, -1, -1, -1, 1, 0, 0, 3, 0, 0, 0);
    tick();

    // legal move (2,3); inputs during the move must be ignored
    push_ev(K_DET, 8, 2, 3); push_ev(K_WR, 8, 1, 19); push_ev(K_OK, 3, 0, 0);
    push_sweep();
    do_move(3'd2, 3'd3, 8'h04, 1'b0);
    move_x = 3'd7; move_y = 3'd7; move_valid = 1'b1; pass_req = 1'b1;
    repeat (3) tick();
    move_valid = 1'b0; pass_req = 1'b0;
    wait_ready("move1");
    push_snap(4, 0, -1, -1, -1, 1, 0, 0, 2, 0, 2, 3);
    tick();

    // illegal move (5,1)
    push_ev(K_DET, 8, 5, 1); push_ev(K_BAD, 2, 1, 0);
    do_move(3'd5, 3'd1, 8'h00, 1'b0);
    wait_ready("move2");
    push_snap(5, 0, -1, -1, -1, 1, 0, 0, 2, 0, 5, 1);
    tick();

    // legal move (1,1) with a 10-cycle renderer stall at cell 5
    push_ev(K_DET, 8, 1, 1); push_ev(K_WR, 8, 1, 9); push_ev(K_OK, 2, 0, 0);
    push_sweep();
    do_move(3'd1, 3'd1, 8'h10, 1'b0);
    wait_ok("move3");
    tick();
    repeat (5) tick();
    plot_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_snap(10 + i, 1, 74, 9, 1, 0, 0, 0, 3, 0, 5, 0);
      tick();
    end
    plot_ready = 1'b1;
    wait_ready("move3_sweep");
    push_snap(6, 0, -1, -1, -1, 1, 0, 0, 3, 0, 1, 1);
    tick();

    // pass, then move+pass together (move wins), then second pass ends the game
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    push_snap(7, -1, -1, -1, -1, 1, 0, 0, 2, 0, -1, -1);
    tick();
    push_ev(K_DET, 8, 6, 7); push_ev(K_BAD, 2, 1, 0);
    do_move(3'd6, 3'd7, 8'h00, 1'b1);
    wait_ready("move4");
    push_snap(8, -1, -1, -1, -1, 1, 0, 0, 2, 0, 6, 7);
    tick();
    push_ev(K_GO, 3, 0, 0);
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    push_snap(9, -1, -1, -1, -1, 1, 0, 0, 3, 1, -1, -1);
    tick();

    // after game over nothing is accepted
    dir = 8'h04; move_x = 3'd0; move_y = 3'd0; move_valid = 1'b1; pass_req = 1'b1;
    repeat (4) tick();
    move_valid = 1'b0;
    repeat (2) tick();
    pass_req = 1'b0;
    push_snap(20, 0, -1, -1, -1, 1, 0, 0, 3, 1, 6, 7);
    tick();

    // reset clears game over and repaints
    resetn = 1'b0;
    push_snap(21, 0, -1, -1, -1, 0, 0, 0, 3, 0, 0, 0);
    tick();
    push_sweep();
    resetn = 1'b1;
    tick();
    wait_ready("sweep_rst1");

    // reset in the middle of a detect phase
    push_ev(K_DET, 2, 3, 4);
    do_move(3'd3, 3'd4, 8'h04, 1'b0);
    tick(); tick();
    resetn = 1'b0;
    push_snap(22, 0, -1, -1, -1, 0, 0, 0, 3, 0, 0, 0);
    tick();
    push_sweep();
    resetn = 1'b1;
    tick();
    wait_ready("sweep_rst2");
    push_snap(23, 0, -1, -1, -1, 1, 0, 0, 3, 0, 0, 0);
    tick();

    done = 1'b1;
    repeat (5) tick();
  end

endmodule
